// File: rtl/io_controller.sv
// Host-link endpoint: decodes the job header, packs 16-bit host halves into
// instruction/data SRAM writes, kicks the core, then streams results out bytewise.
module io_controller #(
    parameter int IN_WIDTH    = 16,
    parameter int OUT_WIDTH   = 8,
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 16,
    parameter int NUM_CONFIGS = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [IN_WIDTH-1:0]   input_data,
    input  logic                  input_vld,
    output logic                  input_rdy,
    output logic [OUT_WIDTH-1:0]  output_data,
    output logic                  output_vld,
    input  logic                  output_rdy,
    output logic                  instr_wen,
    output logic [ADDR_WIDTH-1:0] instr_wadr,
    output logic [DATA_WIDTH-1:0] instr_wdata,
    output logic                  dmem_wen,
    output logic [ADDR_WIDTH-1:0] dmem_wadr,
    output logic [DATA_WIDTH-1:0] dmem_wdata,
    output logic                  dmem_ren,
    output logic [ADDR_WIDTH-1:0] dmem_radr,
    input  logic [DATA_WIDTH-1:0] dmem_rdata,
    output logic                  start,
    input  logic                  done
);

    localparam logic [2:0] CFG_LAST = 3'(NUM_CONFIGS - 1);

    typedef enum logic [2:0] {
        ST_CFG      = 3'd0,
        ST_INSTR    = 3'd1,
        ST_DATA     = 3'd2,
        ST_RUN      = 3'd3,
        ST_WAIT     = 3'd4,
        ST_OUT_RD   = 3'd5,
        ST_OUT_CAP  = 3'd6,
        ST_OUT_SEND = 3'd7
    } state_t;

    function automatic logic [OUT_WIDTH-1:0] byte_lane(input logic [DATA_WIDTH-1:0] word,
                                                       input logic [1:0] lane);
        logic [OUT_WIDTH-1:0] sel;
        case (lane)
            2'd0:    sel = word[0*OUT_WIDTH +: OUT_WIDTH];
            2'd1:    sel = word[1*OUT_WIDTH +: OUT_WIDTH];
            2'd2:    sel = word[2*OUT_WIDTH +: OUT_WIDTH];
            2'd3:    sel = word[3*OUT_WIDTH +: OUT_WIDTH];
            default: sel = {OUT_WIDTH{1'b0}};
        endcase
        return sel;
    endfunction

    state_t                state_r, state_s;
    logic [2:0]            cfg_cnt_r, cfg_cnt_s;
    logic [ADDR_WIDTH-1:0] instr_max_wadr_r, instr_max_wadr_s;
    logic [ADDR_WIDTH-1:0] input_max_wadr_r, input_max_wadr_s;
    logic [ADDR_WIDTH-1:0] input_wadr_offset_r, input_wadr_offset_s;
    logic [ADDR_WIDTH-1:0] output_max_adr_r, output_max_adr_s;
    logic [ADDR_WIDTH-1:0] output_adr_offset_r, output_adr_offset_s;
    logic                  half_r, half_s;
    logic [IN_WIDTH-1:0]   low_half_r, low_half_s;
    logic [ADDR_WIDTH-1:0] idx_r, idx_s;
    logic [ADDR_WIDTH-1:0] byte_idx_r, byte_idx_s, byte_idx_inc_s;
    logic [DATA_WIDTH-1:0] word_r, word_s;
    logic                  input_rdy_r, input_rdy_s;
    logic [OUT_WIDTH-1:0]  output_data_r, output_data_s;
    logic                  output_vld_r, output_vld_s;
    logic                  instr_wen_r, instr_wen_s;
    logic [ADDR_WIDTH-1:0] instr_wadr_r, instr_wadr_s;
    logic [DATA_WIDTH-1:0] instr_wdata_r, instr_wdata_s;
    logic                  dmem_wen_r, dmem_wen_s;
    logic [ADDR_WIDTH-1:0] dmem_wadr_r, dmem_wadr_s;
    logic [DATA_WIDTH-1:0] dmem_wdata_r, dmem_wdata_s;
    logic                  dmem_ren_r, dmem_ren_s;
    logic [ADDR_WIDTH-1:0] dmem_radr_r, dmem_radr_s;
    logic                  start_r, start_s;
    logic                  in_xfer_s, out_xfer_s;

    assign in_xfer_s      = input_vld & input_rdy_r;
    assign out_xfer_s     = output_vld_r & output_rdy;
    assign byte_idx_inc_s = byte_idx_r + ADDR_WIDTH'(1);

    // Next-state and next-output decode; every output is registered below.
    always_comb begin
        state_s             = state_r;
        cfg_cnt_s           = cfg_cnt_r;
        instr_max_wadr_s    = instr_max_wadr_r;
        input_max_wadr_s    = input_max_wadr_r;
        input_wadr_offset_s = input_wadr_offset_r;
        output_max_adr_s    = output_max_adr_r;
        output_adr_offset_s = output_adr_offset_r;
        half_s              = half_r;
        low_half_s          = low_half_r;
        idx_s               = idx_r;
        byte_idx_s          = byte_idx_r;
        word_s              = word_r;
        output_data_s       = output_data_r;
        output_vld_s        = output_vld_r;
        instr_wen_s         = 1'b0;
        instr_wadr_s        = instr_wadr_r;
        instr_wdata_s       = instr_wdata_r;
        dmem_wen_s          = 1'b0;
        dmem_wadr_s         = dmem_wadr_r;
        dmem_wdata_s        = dmem_wdata_r;
        dmem_ren_s          = 1'b0;
        dmem_radr_s         = dmem_radr_r;
        start_s             = 1'b0;

        case (state_r)
            ST_CFG: begin
                if (in_xfer_s) begin
                    case (cfg_cnt_r)
                        3'd0:    instr_max_wadr_s    = input_data;
                        3'd1:    input_max_wadr_s    = input_data;
                        3'd2:    input_wadr_offset_s = input_data;
                        3'd3:    output_max_adr_s    = input_data;
                        3'd4:    output_adr_offset_s = input_data;
                        default: cfg_cnt_s           = cfg_cnt_r;
                    endcase
                    if (cfg_cnt_r == CFG_LAST) begin
                        cfg_cnt_s = 3'd0;
                        state_s   = ST_INSTR;
                    end else begin
                        cfg_cnt_s = cfg_cnt_r + 3'd1;
                    end
                end else begin
                    cfg_cnt_s = cfg_cnt_r;
                end
            end
            ST_INSTR: begin
                if (in_xfer_s) begin
                    if (!half_r) begin
                        low_half_s = input_data;
                        half_s     = 1'b1;
                    end else begin
                        half_s        = 1'b0;
                        instr_wen_s   = 1'b1;
                        instr_wadr_s  = idx_r;
                        instr_wdata_s = {input_data, low_half_r};
                        if (idx_r == instr_max_wadr_r) begin
                            idx_s   = {ADDR_WIDTH{1'b0}};
                            state_s = ST_DATA;
                        end else begin
                            idx_s = idx_r + ADDR_WIDTH'(1);
                        end
                    end
                end else begin
                    half_s = half_r;
                end
            end
            ST_DATA: begin
                if (in_xfer_s) begin
                    if (!half_r) begin
                        low_half_s = input_data;
                        half_s     = 1'b1;
                    end else begin
                        half_s       = 1'b0;
                        dmem_wen_s   = 1'b1;
                        dmem_wadr_s  = input_wadr_offset_r + idx_r;
                        dmem_wdata_s = {input_data, low_half_r};
                        if (idx_r == input_max_wadr_r) begin
                            idx_s   = {ADDR_WIDTH{1'b0}};
                            state_s = ST_RUN;
                        end else begin
                            idx_s = idx_r + ADDR_WIDTH'(1);
                        end
                    end
                end else begin
                    half_s = half_r;
                end
            end
            ST_RUN: begin
                start_s = 1'b1;
                state_s = ST_WAIT;
            end
            ST_WAIT: begin
                // start_r high means this is the start cycle itself: done is not trusted yet
                if (done && !start_r) begin
                    dmem_ren_s  = 1'b1;
                    dmem_radr_s = output_adr_offset_r + {2'b00, byte_idx_r[ADDR_WIDTH-1:2]};
                    state_s     = ST_OUT_RD;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_OUT_RD: begin
                state_s = ST_OUT_CAP;
            end
            ST_OUT_CAP: begin
                word_s        = dmem_rdata;
                output_data_s = byte_lane(dmem_rdata, byte_idx_r[1:0]);
                output_vld_s  = 1'b1;
                state_s       = ST_OUT_SEND;
            end
            ST_OUT_SEND: begin
                if (out_xfer_s) begin
                    if (byte_idx_r == output_max_adr_r) begin
                        output_vld_s  = 1'b0;
                        output_data_s = {OUT_WIDTH{1'b0}};
                        byte_idx_s    = {ADDR_WIDTH{1'b0}};
                        state_s       = ST_CFG;
                    end else begin
                        byte_idx_s = byte_idx_inc_s;
                        if (byte_idx_inc_s[1:0] == 2'b00) begin
                            output_vld_s = 1'b0;
                            dmem_ren_s   = 1'b1;
                            dmem_radr_s  = output_adr_offset_r +
                                           {2'b00, byte_idx_inc_s[ADDR_WIDTH-1:2]};
                            state_s      = ST_OUT_RD;
                        end else begin
                            output_data_s = byte_lane(word_r, byte_idx_inc_s[1:0]);
                        end
                    end
                end else begin
                    output_vld_s = output_vld_r;
                end
            end
            default: state_s = ST_CFG;
        endcase

        input_rdy_s = (state_s == ST_CFG) || (state_s == ST_INSTR) || (state_s == ST_DATA);
    end

    // State, configuration and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r             <= ST_CFG;
            cfg_cnt_r           <= 3'd0;
            instr_max_wadr_r    <= {ADDR_WIDTH{1'b0}};
            input_max_wadr_r    <= {ADDR_WIDTH{1'b0}};
            input_wadr_offset_r <= {ADDR_WIDTH{1'b0}};
            output_max_adr_r    <= {ADDR_WIDTH{1'b0}};
            output_adr_offset_r <= {ADDR_WIDTH{1'b0}};
            half_r              <= 1'b0;
            low_half_r          <= {IN_WIDTH{1'b0}};
            idx_r               <= {ADDR_WIDTH{1'b0}};
            byte_idx_r          <= {ADDR_WIDTH{1'b0}};
            word_r              <= {DATA_WIDTH{1'b0}};
            input_rdy_r         <= 1'b0;
            output_data_r       <= {OUT_WIDTH{1'b0}};
            output_vld_r        <= 1'b0;
            instr_wen_r         <= 1'b0;
            instr_wadr_r        <= {ADDR_WIDTH{1'b0}};
            instr_wdata_r       <= {DATA_WIDTH{1'b0}};
            dmem_wen_r          <= 1'b0;
            dmem_wadr_r         <= {ADDR_WIDTH{1'b0}};
            dmem_wdata_r        <= {DATA_WIDTH{1'b0}};
            dmem_ren_r          <= 1'b0;
            dmem_radr_r         <= {ADDR_WIDTH{1'b0}};
            start_r             <= 1'b0;
        end else begin
            state_r             <= state_s;
            cfg_cnt_r           <= cfg_cnt_s;
            instr_max_wadr_r    <= instr_max_wadr_s;
            input_max_wadr_r    <= input_max_wadr_s;
            input_wadr_offset_r <= input_wadr_offset_s;
            output_max_adr_r    <= output_max_adr_s;
            output_adr_offset_r <= output_adr_offset_s;
            half_r              <= half_s;
            low_half_r          <= low_half_s;
            idx_r               <= idx_s;
            byte_idx_r          <= byte_idx_s;
            word_r              <= word_s;
            input_rdy_r         <= input_rdy_s;
            output_data_r       <= output_data_s;
            output_vld_r        <= output_vld_s;
            instr_wen_r         <= instr_wen_s;
            instr_wadr_r        <= instr_wadr_s;
            instr_wdata_r       <= instr_wdata_s;
            dmem_wen_r          <= dmem_wen_s;
            dmem_wadr_r         <= dmem_wadr_s;
            dmem_wdata_r        <= dmem_wdata_s;
            dmem_ren_r          <= dmem_ren_s;
            dmem_radr_r         <= dmem_radr_s;
            start_r             <= start_s;
        end
    end

    assign input_rdy   = input_rdy_r;
    assign output_data = output_data_r;
    assign output_vld  = output_vld_r;
    assign instr_wen   = instr_wen_r;
    assign instr_wadr  = instr_wadr_r;
    assign instr_wdata = instr_wdata_r;
    assign dmem_wen    = dmem_wen_r;
    assign dmem_wadr   = dmem_wadr_r;
    assign dmem_wdata  = dmem_wdata_r;
    assign dmem_ren    = dmem_ren_r;
    assign dmem_radr   = dmem_radr_r;
    assign start       = start_r;

endmodule

// File: tb/tb_io_controller.sv
// Directed bench for io_controller: header/instr/data load, start/done handshake,
// byte unload with backpressure, input gaps and a mid-INSTR reset.
module tb_io_controller;

    logic        clk;
    logic        rst_n;
    logic [15:0] input_data;
    logic        input_vld;
    logic        input_rdy;
    logic [7:0]  output_data;
    logic        output_vld;
    logic        output_rdy;
    logic        instr_wen;
    logic [15:0] instr_wadr;
    logic [31:0] instr_wdata;
    logic        dmem_wen;
    logic [15:0] dmem_wadr;
    logic [31:0] dmem_wdata;
    logic        dmem_ren;
    logic [15:0] dmem_radr;
    logic [31:0] dmem_rdata;
    logic        start;
    logic        done;

    io_controller dut (
        .clk(clk), .rst_n(rst_n),
        .input_data(input_data), .input_vld(input_vld), .input_rdy(input_rdy),
        .output_data(output_data), .output_vld(output_vld), .output_rdy(output_rdy),
        .instr_wen(instr_wen), .instr_wadr(instr_wadr), .instr_wdata(instr_wdata),
        .dmem_wen(dmem_wen), .dmem_wadr(dmem_wadr), .dmem_wdata(dmem_wdata),
        .dmem_ren(dmem_ren), .dmem_radr(dmem_radr), .dmem_rdata(dmem_rdata),
        .start(start), .done(done)
    );

    int total = 0;
    int bad   = 0;

    logic [47:0] iw_q[$];
    logic [47:0] dw_q[$];
    logic [15:0] rd_q[$];
    logic [7:0]  ob_q[$];
    int          cyc = 0;
    int          start_cnt = 0;
    int          start_cyc = 0;
    int          last_dw_cyc = 0;
    int          excl_viol = 0;
    int          stab_viol = 0;
    logic        prev_hold = 1'b0;
    logic [7:0]  prev_data = 8'h00;
    logic [3:0]  pat = 4'b1001;

    logic [15:0] hdr1 [5] = '{16'h0003, 16'h0001, 16'h07D0, 16'h0007, 16'h07E8};
    logic [15:0] ins1 [8] = '{16'h1111, 16'hAAAA, 16'h2222, 16'hBBBB,
                              16'h3333, 16'hCCCC, 16'h4444, 16'hDDDD};
    logic [15:0] dat1 [4] = '{16'h0001, 16'h0000, 16'h0002, 16'h0000};
    logic [47:0] exp_iw [4] = '{{16'h0000, 32'hAAAA1111}, {16'h0001, 32'hBBBB2222},
                                {16'h0002, 32'hCCCC3333}, {16'h0003, 32'hDDDD4444}};
    logic [47:0] exp_dw [2] = '{{16'h07D0, 32'h00000001}, {16'h07D1, 32'h00000002}};
    logic [7:0]  exp_ob [8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    logic [15:0] hdr3 [5] = '{16'h0001, 16'h0000, 16'h0100, 16'h0003, 16'h0200};
    logic [7:0]  exp_ob3 [4] = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data-memory read model: one cycle of latency, garbage when not reading.
    always @(posedge clk) begin
        if (dmem_ren) begin
            case (dmem_radr)
                16'h07E8: dmem_rdata <= 32'h44332211;
                16'h07E9: dmem_rdata <= 32'h88776655;
                16'h0200: dmem_rdata <= 32'hA1B2C3D4;
                default:  dmem_rdata <= 32'hDEADBEEF;
            endcase
        end else begin
            dmem_rdata <= 32'hBAD0BAD0;
        end
    end

    // Observer on the falling edge: records strobes, bytes and handshake rules.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (instr_wen) iw_q.push_back({instr_wadr, instr_wdata});
        if (dmem_wen) begin
            dw_q.push_back({dmem_wadr, dmem_wdata});
            last_dw_cyc = cyc;
        end
        if (dmem_ren) rd_q.push_back(dmem_radr);
        if (start) begin
            start_cnt = start_cnt + 1;
            start_cyc = cyc;
        end
        if ((32'(instr_wen) + 32'(dmem_wen) + 32'(dmem_ren)) > 1) excl_viol = excl_viol + 1;
        if (prev_hold && (!output_vld || output_data !== prev_data)) stab_viol = stab_viol + 1;
        if (output_vld && output_rdy) ob_q.push_back(output_data);
        prev_hold = output_vld && !output_rdy;
        prev_data = output_data;
    end

    initial begin
        #300000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total = total + 1;
        assert (obs === exp) else begin
            bad = bad + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic send(input logic [15:0] w);
        int   g;
        logic acc;
        g = 0;
        acc = 1'b0;
        input_data = w;
        input_vld  = 1'b1;
        while (!acc && g < 50) begin
            @(negedge clk);
            acc = input_rdy;
            @(posedge clk);
            #2;
            g = g + 1;
        end
        input_vld = 1'b0;
        chk("send_accept", 64'(acc), 64'h1);
    endtask

    task automatic wait_start(input int n);
        int g;
        g = 0;
        while (start_cnt < n && g < 60) begin
            tick();
            g = g + 1;
        end
        chk("start_count", 64'(start_cnt), 64'(n));
    endtask

    task automatic pulse_done(input int delay);
        idle(delay);
        done = 1'b1;
        tick();
        done = 1'b0;
    endtask

    task automatic unload(input int n, input bit toggle);
        int g;
        int k;
        g = 0;
        k = 0;
        while (ob_q.size() < n && g < 400) begin
            output_rdy = toggle ? pat[k % 4] : 1'b1;
            tick();
            g = g + 1;
            k = k + 1;
        end
        output_rdy = 1'b1;
        chk("unload_count", 64'(ob_q.size()), 64'(n));
    endtask

    initial begin
        int ren_before;
        int iw_before;
        rst_n      = 1'b0;
        input_data = 16'h0000;
        input_vld  = 1'b0;
        output_rdy = 1'b0;
        done       = 1'b0;
        idle(3);

        @(negedge clk);
        chk("rst_ctl", 64'({input_rdy, output_vld, instr_wen, dmem_wen, dmem_ren, start}), 64'h0);
        chk("rst_data", 64'({output_data, instr_wdata}), 64'h0);
        chk("rst_adr", 64'({instr_wadr, dmem_wadr, dmem_radr}), 64'h0);
        chk("rst_dwdata", 64'(dmem_wdata), 64'h0);
        tick();
        rst_n = 1'b1;
        tick();
        @(negedge clk);
        chk("rdy_after_rst", 64'(input_rdy), 64'h1);
        tick();

        // Job 1: gap-free load, full-rate unload
        output_rdy = 1'b1;
        for (int i = 0; i < 5; i++) send(hdr1[i]);
        for (int i = 0; i < 8; i++) send(ins1[i]);
        for (int i = 0; i < 4; i++) send(dat1[i]);
        input_data = 16'hFFFF;
        input_vld  = 1'b1;
        wait_start(1);
        @(negedge clk);
        chk("rdy_low_after_load", 64'(input_rdy), 64'h0);
        chk("start_after_last_wr", 64'(start_cyc), 64'(last_dw_cyc + 1));
        idle(3);
        input_vld = 1'b0;
        chk("j1_iw_count", 64'(iw_q.size()), 64'd4);
        for (int i = 0; i < 4; i++) chk("j1_iw", 64'(iw_q[i]), 64'(exp_iw[i]));
        chk("j1_dw_count", 64'(dw_q.size()), 64'd2);
        for (int i = 0; i < 2; i++) chk("j1_dw", 64'(dw_q[i]), 64'(exp_dw[i]));
        pulse_done(2);
        unload(8, 1'b0);
        for (int i = 0; i < 8; i++) chk("j1_byte", 64'(ob_q[i]), 64'(exp_ob[i]));
        @(negedge clk);
        chk("j1_vld_end", 64'(output_vld), 64'h0);
        chk("j1_rdy_end", 64'(input_rdy), 64'h1);
        chk("j1_reads", 64'({rd_q.size() == 2, rd_q[0], rd_q[1]}), 64'({1'b1, 16'h07E8, 16'h07E9}));
        chk("j1_start_once", 64'(start_cnt), 64'd1);
        tick();

        // Job 2: idle gaps on input, early done, throttled unload
        for (int i = 0; i < 5; i++) begin
            send(hdr1[i]);
            if (i < 4) idle(3);
        end
        for (int i = 0; i < 8; i++) begin
            send(ins1[i]);
            idle(2);
        end
        for (int i = 0; i < 4; i++) begin
            send(dat1[i]);
            if (i < 3) idle(1);
        end
        done = 1'b1;
        tick();
        tick();
        done = 1'b0;
        chk("j2_start_count", 64'(start_cnt), 64'd2);
        chk("j2_start_after_last_wr", 64'(start_cyc), 64'(last_dw_cyc + 1));
        ren_before = rd_q.size();
        idle(4);
        chk("j2_early_done_ignored", 64'(rd_q.size()), 64'(ren_before));
        chk("j2_no_vld_before_done", 64'(output_vld), 64'h0);
        chk("j2_iw_count", 64'(iw_q.size()), 64'd8);
        for (int i = 0; i < 4; i++) chk("j2_iw", 64'(iw_q[4 + i]), 64'(exp_iw[i]));
        chk("j2_dw_count", 64'(dw_q.size()), 64'd4);
        for (int i = 0; i < 2; i++) chk("j2_dw", 64'(dw_q[2 + i]), 64'(exp_dw[i]));
        pulse_done(1);
        unload(16, 1'b1);
        for (int i = 0; i < 8; i++) chk("j2_byte", 64'(ob_q[8 + i]), 64'(exp_ob[i]));
        chk("j2_stable_hold", 64'(stab_viol), 64'h0);
        @(negedge clk);
        chk("j2_vld_end", 64'(output_vld), 64'h0);
        tick();

        // Job 3: reset after an odd number of instr halves, then a fresh job
        for (int i = 0; i < 5; i++) send(hdr3[i]);
        send(16'h1111);
        send(16'hAAAA);
        send(16'h2222);
        chk("j3_pre_rst_iw", 64'({iw_q.size() == 9, iw_q[8]}), 64'({1'b1, 16'h0000, 32'hAAAA1111}));
        iw_before  = iw_q.size();
        ren_before = rd_q.size();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        idle(3);
        chk("j3_no_strobe_after_rst",
            64'({iw_q.size() == iw_before, dw_q.size() == 4, rd_q.size() == ren_before, start_cnt == 2}),
            64'hF);
        for (int i = 0; i < 5; i++) send(hdr3[i]);
        send(16'h5555);
        send(16'h6666);
        send(16'h7777);
        send(16'h8888);
        send(16'h1234);
        send(16'h5678);
        wait_start(3);
        chk("j3_iw0", 64'(iw_q[9]), 64'({16'h0000, 32'h66665555}));
        chk("j3_iw1", 64'(iw_q[10]), 64'({16'h0001, 32'h88887777}));
        chk("j3_dw0", 64'({dw_q.size() == 5, dw_q[4]}), 64'({1'b1, 16'h0100, 32'h56781234}));
        pulse_done(3);
        unload(20, 1'b0);
        for (int i = 0; i < 4; i++) chk("j3_byte", 64'(ob_q[16 + i]), 64'(exp_ob3[i]));
        chk("j3_read_adr", 64'(rd_q[4]), 64'h0200);
        @(negedge clk);
        chk("j3_end", 64'({output_vld, input_rdy}), 64'h1);
        chk("strobe_exclusive", 64'(excl_viol), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
